hyper_reg_sequencer: RTL and testbench

Register-bus sequencer and arbiter in front of the hyperbus controller's configuration port. After reset it programs a fixed table of controller registers (latency, timing, chip-select config). It then shares the single regbus slave port between `NumMasters` requesters with round-robin arbitration. A per-access timeout guards against a hung slave. Sits in the `sys_clk` domain between the SoC regbus masters and the `reg_req`/`reg_rsp` port of the hyperbus controller.

---
 rtl/hyper_reg_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_hyper_reg_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hyper_reg_sequencer.sv
// hyper_reg_sequencer: programs a boot table of hyperbus controller
// registers, then round-robin arbitrates NumMasters regbus masters onto the
// single controller configuration port, with a per-access timeout.
module hyper_reg_sequencer #(
  parameter int unsigned                NumMasters    = 2,
  parameter int unsigned                NumInit       = 4,
  parameter logic [NumInit-1:0][31:0]   InitAddr      = '0,
  parameter logic [NumInit-1:0][31:0]   InitData      = '0,
  parameter int unsigned                TimeoutCycles = 255
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic [NumMasters-1:0]        mst_valid_i,
  input  logic [NumMasters-1:0]        mst_write_i,
  input  logic [NumMasters-1:0][31:0]  mst_addr_i,
  input  logic [NumMasters-1:0][31:0]  mst_wdata_i,
  input  logic [NumMasters-1:0][3:0]   mst_wstrb_i,
  output logic [NumMasters-1:0]        mst_ready_o,
  output logic [31:0]                  mst_rdata_o,
  output logic                         mst_error_o,
  output logic                         reg_valid_o,
  output logic                         reg_write_o,
  output logic [31:0]                  reg_addr_o,
  output logic [31:0]                  reg_wdata_o,
  output logic [3:0]                   reg_wstrb_o,
  input  logic                         reg_ready_i,
  input  logic [31:0]                  reg_rdata_i,
  input  logic                         reg_error_i,
  output logic                         init_done_o,
  output logic                         init_error_o,
  output logic                         busy_o
);

  typedef enum logic [2:0] {
    S_INIT_REQ,
    S_INIT_WAIT,
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam int unsigned PW          = (NumMasters > 1) ? $clog2(NumMasters) : 1;
  localparam int unsigned IW          = $clog2(NumInit + 2);
  localparam state_e      ResetState  = (NumInit > 0) ? S_INIT_REQ : S_IDLE;
  localparam logic        ResetBusy   = (NumInit > 0);
  localparam logic        ResetDone   = (NumInit == 0);
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
  localparam logic [IW-1:0] InitLast  = IW'(NumInit - 1);
  localparam logic [PW-1:0] PtrLast   = PW'(NumMasters - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           k_q, k_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [PW-1:0]           p_q, p_d;
  logic [NumMasters-1:0]   grant_q, grant_d;
  logic                    reg_valid_q, reg_valid_d;
  logic                    reg_write_q, reg_write_d;
  logic [31:0]             reg_addr_q, reg_addr_d;
  logic [31:0]             reg_wdata_q, reg_wdata_d;
  logic [3:0]              reg_wstrb_q, reg_wstrb_d;
  logic [NumMasters-1:0]   mst_ready_q, mst_ready_d;
  logic [31:0]             mst_rdata_q, mst_rdata_d;
  logic                    mst_error_q, mst_error_d;
  logic                    init_done_q, init_done_d;
  logic                    init_error_q, init_error_d;
  logic                    busy_q, busy_d;

  logic [31:0]             init_addr, init_data;
  logic                    arb_found;
  logic [PW-1:0]           arb_idx;
  logic [NumMasters-1:0]   arb_oh;
  logic                    sel_write;
  logic [31:0]             sel_addr, sel_wdata;
  logic [3:0]              sel_wstrb;
  logic                    timeout_hit;

  // Boot table entry for the current init index; empty table has no entries.
  if (NumInit > 0) begin : g_init_tbl
    always_comb begin
      init_addr = '0;
      init_data = '0;
      for (int i = 0; i < NumInit; i++) begin
        if (k_q == IW'(i)) begin
          init_addr = InitAddr[i];
          init_data = InitData[i];
        end
      end
    end
  end else begin : g_no_init_tbl
    assign init_addr = '0;
    assign init_data = '0;
  end

  // Round-robin pick: first requester at or above the pointer, else the
  // lowest requester (wrap), then mux that master's request fields.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_oh    = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NumMasters; i++) begin
      if (!arb_found && mst_valid_i[i] && (PW'(i) >= p_q)) begin
        arb_found = 1'b1;
        arb_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NumMasters; i++) begin
      if (!arb_found && mst_valid_i[i]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NumMasters; i++) begin
      if (arb_found && (arb_idx == PW'(i))) begin
        arb_oh[i] = 1'b1;
        sel_write = mst_write_i[i];
        sel_addr  = mst_addr_i[i];
        sel_wdata = mst_wdata_i[i];
        sel_wstrb = mst_wstrb_i[i];
      end
    end
  end

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    grant_d      = grant_q;
    reg_valid_d  = reg_valid_q;
    reg_write_d  = reg_write_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wstrb_d  = reg_wstrb_q;
    mst_ready_d  = mst_ready_q;
    mst_rdata_d  = mst_rdata_q;
    mst_error_d  = mst_error_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    // Ready in the limit cycle takes precedence over the timeout.
    timeout_hit  = !reg_ready_i && (cnt_q == TimeoutLast);

    case (state_q)
      S_INIT_REQ: begin
        reg_valid_d = 1'b1;
        reg_write_d = 1'b1;
        reg_wstrb_d = 4'hF;
        reg_addr_d  = init_addr;
        reg_wdata_d = init_data;
        cnt_d       = '0;
        state_d     = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (reg_ready_i || timeout_hit) begin
          reg_valid_d = 1'b0;
          if (!reg_ready_i || reg_error_i) begin
            init_error_d = 1'b1;
          end
          k_d = k_q + 1'b1;
          if (k_q == InitLast) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_INIT_REQ;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (arb_found) begin
          grant_d     = arb_oh;
          reg_valid_d = 1'b1;
          reg_write_d = sel_write;
          reg_addr_d  = sel_addr;
          reg_wdata_d = sel_wdata;
          reg_wstrb_d = sel_wstrb;
          cnt_d       = '0;
          p_d         = (arb_idx == PtrLast) ? '0 : arb_idx + 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (reg_ready_i) begin
          reg_valid_d = 1'b0;
          mst_rdata_d = reg_rdata_i;
          mst_error_d = reg_error_i;
          mst_ready_d = grant_q;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          reg_valid_d = 1'b0;
          mst_rdata_d = '0;
          mst_error_d = 1'b1;
          mst_ready_d = grant_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        mst_ready_d = '0;
        mst_rdata_d = '0;
        mst_error_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state and outputs registered; reset is asynchronous and high-true.
  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ResetState;
      k_q          <= '0;
      cnt_q        <= '0;
      p_q          <= '0;
      grant_q      <= '0;
      reg_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_wstrb_q  <= '0;
      mst_ready_q  <= '0;
      mst_rdata_q  <= '0;
      mst_error_q  <= 1'b0;
      init_done_q  <= ResetDone;
      init_error_q <= 1'b0;
      busy_q       <= ResetBusy;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      grant_q      <= grant_d;
      reg_valid_q  <= reg_valid_d;
      reg_write_q  <= reg_write_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
      mst_ready_q  <= mst_ready_d;
      mst_rdata_q  <= mst_rdata_d;
      mst_error_q  <= mst_error_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      busy_q       <= busy_d;
    end
  end

  assign mst_ready_o  = mst_ready_q;
  assign mst_rdata_o  = mst_rdata_q;
  assign mst_error_o  = mst_error_q;
  assign reg_valid_o  = reg_valid_q;
  assign reg_write_o  = reg_write_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign reg_wstrb_o  = reg_wstrb_q;
  assign init_done_o  = init_done_q;
  assign init_error_o = init_error_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_hyper_reg_sequencer.sv
// Directed bench for hyper_reg_sequencer: one instance with a 3-entry boot
// table and an 8-cycle timeout, a second with an empty boot table.
module tb_hyper_reg_sequencer;

  localparam logic [2:0][31:0] IA = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
  localparam logic [2:0][31:0] ID = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [1:0]        mv, mw, mrdy;
  logic [1:0][31:0]  ma, md;
  logic [1:0][3:0]   ms;
  logic [31:0]       mrdata, ra, rwd, rrdata;
  logic              merr, rv, rw, rrdy, rerr, done, ierr, busy;
  logic [3:0]        rs;

  logic [1:0]        z_mv, z_mw, z_mrdy;
  logic [1:0][31:0]  z_ma, z_md;
  logic [1:0][3:0]   z_ms;
  logic [31:0]       z_mrdata, z_ra, z_rwd, z_rrdata;
  logic              z_merr, z_rv, z_rw, z_rrdy, z_rerr, z_done, z_ierr, z_busy;
  logic [3:0]        z_rs;

  int n_assert = 0;
  int n_fail   = 0;

  hyper_reg_sequencer #(
    .NumMasters(2), .NumInit(3), .InitAddr(IA), .InitData(ID), .TimeoutCycles(8)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n),
    .mst_valid_i(mv), .mst_write_i(mw), .mst_addr_i(ma), .mst_wdata_i(md),
    .mst_wstrb_i(ms), .mst_ready_o(mrdy), .mst_rdata_o(mrdata), .mst_error_o(merr),
    .reg_valid_o(rv), .reg_write_o(rw), .reg_addr_o(ra), .reg_wdata_o(rwd),
    .reg_wstrb_o(rs), .reg_ready_i(rrdy), .reg_rdata_i(rrdata), .reg_error_i(rerr),
    .init_done_o(done), .init_error_o(ierr), .busy_o(busy)
  );

  hyper_reg_sequencer #(
    .NumMasters(2), .NumInit(0), .TimeoutCycles(8)
  ) dut0 (
    .sys_clk(clk), .rst_n(rst_n),
    .mst_valid_i(z_mv), .mst_write_i(z_mw), .mst_addr_i(z_ma), .mst_wdata_i(z_md),
    .mst_wstrb_i(z_ms), .mst_ready_o(z_mrdy), .mst_rdata_o(z_mrdata), .mst_error_o(z_merr),
    .reg_valid_o(z_rv), .reg_write_o(z_rw), .reg_addr_o(z_ra), .reg_wdata_o(z_rwd),
    .reg_wstrb_o(z_rs), .reg_ready_i(z_rrdy), .reg_rdata_i(z_rrdata), .reg_error_i(z_rerr),
    .init_done_o(z_done), .init_error_o(z_ierr), .busy_o(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    mv = '0; mw = '0; ma = '0; md = '0; ms = '0;
    rrdy = 1'b1; rrdata = 32'hDEAD_BEEF; rerr = 1'b0;
    z_mv = '0; z_mw = '0; z_ma = '0; z_md = '0; z_ms = '0;
    z_rrdy = 1'b0; z_rrdata = 32'hDEAD_BEEF; z_rerr = 1'b0;

    // Reset state of both instances
    step();
    step();
    chkb("rst_reg_valid", rv, 1'b0);
    chkb("rst_busy", busy, 1'b1);
    chkb("rst_done", done, 1'b0);
    chkb("rst_init_err", ierr, 1'b0);
    chk("rst_mst_ready", 32'(mrdy), 32'h0);
    chkb("rst0_busy", z_busy, 1'b0);
    chkb("rst0_done", z_done, 1'b1);
    chkb("rst0_reg_valid", z_rv, 1'b0);
    $display("reset state checked");

    // Boot writes; both masters already requesting and must wait
    mv = 2'b11; mw = 2'b00;
    ma[0] = 32'h0000_0100; ma[1] = 32'h0000_0200;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chkb("boot_valid", rv, 1'b1);
      chkb("boot_write", rw, 1'b1);
      chk("boot_wstrb", 32'(rs), 32'hF);
      chk("boot_addr", ra, IA[n]);
      chk("boot_data", rwd, ID[n]);
      chk("boot_mst_ready", 32'(mrdy), 32'h0);
      $display("boot write %0d addr=%h data=%h", n, ra, rwd);
      step();
      chkb("boot_gap", rv, 1'b0);
      chkb("boot_done", done, (n == 2) ? 1'b1 : 1'b0);
      chk("boot_mst_ready2", 32'(mrdy), 32'h0);
    end
    chkb("boot_init_err", ierr, 1'b0);
    chkb("boot_busy_idle", busy, 1'b0);

    // Contention: grants alternate 0,1,0,1
    for (int n = 0; n < 4; n++) begin
      step();
      chkb("arb_valid", rv, 1'b1);
      chkb("arb_write", rw, 1'b0);
      chk("arb_addr", ra, (n % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      step();
      chk("arb_ready", 32'(mrdy), (n % 2 == 0) ? 32'h1 : 32'h2);
      chk("arb_rdata", mrdata, 32'hDEAD_BEEF);
      chkb("arb_error", merr, 1'b0);
      chkb("arb_valid_drop", rv, 1'b0);
      $display("access %0d ready=%b rdata=%h", n, mrdy, mrdata);
      step();
      chk("arb_ready_pulse", 32'(mrdy), 32'h0);
    end
    mv = 2'b00;

    // Timeout on master 1 read: valid held 8 cycles
    rrdy = 1'b0;
    mv = 2'b10; ma[1] = 32'h0000_0300;
    for (int j = 0; j < 8; j++) begin
      step();
      chkb("to_valid_held", rv, 1'b1);
      chk("to_no_ready", 32'(mrdy), 32'h0);
    end
    step();
    chkb("to_valid_drop", rv, 1'b0);
    chk("to_ready", 32'(mrdy), 32'h2);
    chkb("to_error", merr, 1'b1);
    chk("to_rdata", mrdata, 32'h0);
    $display("timeout access ready=%b error=%b rdata=%h", mrdy, merr, mrdata);
    mv = 2'b00;
    step();

    // Ready arrives exactly in the limit cycle on the empty-table instance
    z_mv = 2'b01; z_ma[0] = 32'h0000_0500;
    step();
    chkb("lim_valid", z_rv, 1'b1);
    for (int j = 1; j < 8; j++) begin
      step();
      chkb("lim_valid_held", z_rv, 1'b1);
      chk("lim_no_ready", 32'(z_mrdy), 32'h0);
    end
    z_rrdy = 1'b1;
    step();
    chk("lim_ready", 32'(z_mrdy), 32'h1);
    chkb("lim_error", z_merr, 1'b0);
    chk("lim_rdata", z_mrdata, 32'hDEAD_BEEF);
    $display("limit access ready=%b error=%b rdata=%h", z_mrdy, z_merr, z_mrdata);
    z_mv = 2'b00; z_rrdy = 1'b0;
    step();

    // Reset asserted while in ACCESS
    rrdy = 1'b0;
    mv = 2'b01; mw = 2'b01; ma[0] = 32'h0000_0400;
    step();
    step();
    chkb("mid_valid_before", rv, 1'b1);
    chk("mid_addr_before", ra, 32'h0000_0400);
    #2;
    rst_n = 1'b1;
    #1;
    chkb("mid_valid_async", rv, 1'b0);
    chk("mid_ready_async", 32'(mrdy), 32'h0);
    chkb("mid_busy_async", busy, 1'b1);
    chkb("mid_done_async", done, 1'b0);
    $display("reset mid-access valid=%b busy=%b", rv, busy);
    mv = 2'b00; mw = 2'b00;
    @(negedge clk);
    chkb("mid_valid_held", rv, 1'b0);

    // Boot rerun from index 0 with an error on the first write
    rrdy = 1'b1; rerr = 1'b1;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chkb("berr_valid", rv, 1'b1);
      chk("berr_addr", ra, IA[n]);
      chk("berr_data", rwd, ID[n]);
      step();
      rerr = 1'b0;
      chkb("berr_sticky", ierr, 1'b1);
      chkb("berr_done", done, (n == 2) ? 1'b1 : 1'b0);
      $display("boot-err write %0d init_error=%b done=%b", n, ierr, done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
